// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - framed program image loader with XOR check and core reset release
//
// Ports:
//   CLK, Reset_L              clock, asynchronous active-low reset
//   in_valid/in_ready/in_data 32-bit word stream carrying header, payload, checksum
//   reload                    one-cycle request to reload (RUN or ERROR only)
//   imem_we/imem_addr/imem_wdata  registered instruction memory write port
//   proc_reset_l, startPC     registered processor reset and start PC
//   done, error               image verified and running / sticky load failure
module imem_boot_loader #(
  parameter int          DEPTH   = 256,
  parameter logic [63:0] BASE_PC = 64'h0
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        reload,
  output logic        imem_we,
  output logic [63:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        proc_reset_l,
  output logic [63:0] startPC,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    ST_HDR,
    ST_LOAD,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [15:0] s_q, s_d;
  logic [15:0] k_q, k_d;
  logic [31:0] xor_q, xor_d;
  logic        imem_we_q, imem_we_d;
  logic [63:0] imem_addr_q, imem_addr_d;
  logic [31:0] imem_wdata_q, imem_wdata_d;
  logic        proc_reset_l_q, proc_reset_l_d;
  logic [63:0] start_pc_q, start_pc_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        accept;
  logic [16:0] hdr_span;
  logic [15:0] k_inc;
  logic [63:0] load_word_idx;

  // The stream is only open while an image is being received.
  assign in_ready = (state_q == ST_HDR) || (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign accept   = in_valid && in_ready;

  // Header bounds check in 17 bits so S+N cannot wrap past DEPTH.
  assign hdr_span      = {1'b0, in_data[31:16]} + {1'b0, in_data[15:0]};
  assign k_inc         = k_q + 16'd1;
  assign load_word_idx = 64'(s_q) + 64'(k_q);

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    s_d            = s_q;
    k_d            = k_q;
    xor_d          = xor_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    proc_reset_l_d = proc_reset_l_q;
    start_pc_d     = start_pc_q;
    done_d         = done_q;
    error_d        = error_q;

    case (state_q)
      ST_HDR: begin
        if (accept) begin
          n_d   = in_data[15:0];
          s_d   = in_data[31:16];
          k_d   = 16'd0;
          // The header itself is folded into the checksum.
          xor_d = in_data;
          if (hdr_span > 17'(DEPTH)) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else if (in_data[15:0] == 16'd0) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (accept) begin
          imem_we_d    = 1'b1;
          imem_wdata_d = in_data;
          imem_addr_d  = BASE_PC + (load_word_idx << 2);
          xor_d        = xor_q ^ in_data;
          k_d          = k_inc;
          if (k_inc == n_q) begin
            state_d = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        if (accept) begin
          if (in_data == xor_q) begin
            state_d        = ST_RUN;
            proc_reset_l_d = 1'b1;
            done_d         = 1'b1;
            start_pc_d     = BASE_PC + (64'(s_q) << 2);
          end else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (reload) begin
          state_d        = ST_HDR;
          proc_reset_l_d = 1'b0;
          done_d         = 1'b0;
        end
      end

      ST_ERROR: begin
        if (reload) begin
          state_d = ST_HDR;
          error_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_HDR;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q        <= ST_HDR;
      n_q            <= 16'd0;
      s_q            <= 16'd0;
      k_q            <= 16'd0;
      xor_q          <= 32'd0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= 64'd0;
      imem_wdata_q   <= 32'd0;
      proc_reset_l_q <= 1'b0;
      start_pc_q     <= BASE_PC;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      s_q            <= s_d;
      k_q            <= k_d;
      xor_q          <= xor_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      proc_reset_l_q <= proc_reset_l_d;
      start_pc_q     <= start_pc_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign proc_reset_l = proc_reset_l_q;
  assign startPC      = start_pc_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - scoreboard bench for imem_boot_loader
module tb_imem_boot_loader;

  localparam int          DEPTH = 256;
  localparam logic [63:0] BASE  = 64'h0000_0000_8000_1000;

  logic        clk;
  logic        Reset_L;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        reload;
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        proc_reset_l;
  logic [63:0] startPC;
  logic        done;
  logic        error;

  imem_boot_loader #(.DEPTH(DEPTH), .BASE_PC(BASE)) dut (
    .CLK          (clk),
    .Reset_L      (Reset_L),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .reload       (reload),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .proc_reset_l (proc_reset_l),
    .startPC      (startPC),
    .done         (done),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int wcount = 0;
  logic [95:0] sb[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every write pulse is compared against the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wcount++;
      if (sb.size() == 0) begin
        check_eq("unexpected_we", 64'(imem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [95:0] e;
        e = sb.pop_front();
        check_eq("wr_addr", imem_addr, e[95:32]);
        check_eq("wr_data", 64'(imem_wdata), 64'(e[31:0]));
      end
    end
  end

  // Drive one word at posedge+1; it is accepted at the next posedge.
  task automatic send(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    if (in_ready !== 1'b1) check_eq("send_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic load_frame(input int n, input int s, input bit corrupt,
                            input bit fixed, input bit gaps, input int stop_after);
    logic [31:0] hdr, x, w;
    logic [63:0] a;
    hdr = {s[15:0], n[15:0]};
    x   = hdr;
    send(hdr);
    for (int i = 0; i < n; i++) begin
      if (i == stop_after) return;
      w = fixed ? 32'h11 * (i + 1) : $urandom;
      x = x ^ w;
      a = BASE + 64'(4 * (s + i));
      sb.push_back({a, w});
      if (gaps) repeat ($urandom_range(0, 3)) @(posedge clk);
      if (gaps) #1;
      send(w);
    end
    send(corrupt ? (x ^ 32'h0000_0100) : x);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    check_eq("reload_prst", 64'(proc_reset_l), 64'd0);
    check_eq("reload_done", 64'(done), 64'd0);
    check_eq("reload_err", 64'(error), 64'd0);
    check_eq("reload_rdy", 64'(in_ready), 64'd1);
  endtask

  task automatic expect_run(input string tag, input int s);
    check_eq({tag, "_prst"}, 64'(proc_reset_l), 64'd1);
    check_eq({tag, "_done"}, 64'(done), 64'd1);
    check_eq({tag, "_err"}, 64'(error), 64'd0);
    check_eq({tag, "_rdy"}, 64'(in_ready), 64'd0);
    check_eq({tag, "_pc"}, startPC, BASE + 64'(4 * s));
    check_eq({tag, "_sb"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int w0;
    int gapless_cnt, gappy_cnt;
    logic [63:0] gapless_pc;
    Reset_L  = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'd0;
    reload   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_we", 64'(imem_we), 64'd0);
    check_eq("rst_addr", imem_addr, 64'd0);
    check_eq("rst_wdata", 64'(imem_wdata), 64'd0);
    check_eq("rst_prst", 64'(proc_reset_l), 64'd0);
    check_eq("rst_pc", startPC, BASE);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_err", 64'(error), 64'd0);
    Reset_L = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_rdy", 64'(in_ready), 64'd1);

    // Basic frame N=3, S=4.
    w0 = wcount;
    load_frame(3, 4, 1'b0, 1'b1, 1'b0, -1);
    expect_run("basic", 4);
    check_eq("basic_wcnt", 64'(wcount - w0), 64'd3);

    // in_valid while RUN is ignored.
    w0 = wcount;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("run_hold_done", 64'(done), 64'd1);
    check_eq("run_hold_wcnt", 64'(wcount - w0), 64'd0);
    do_reload();

    // Corrupted checksum.
    load_frame(3, 4, 1'b1, 1'b1, 1'b0, -1);
    check_eq("bad_ck_err", 64'(error), 64'd1);
    check_eq("bad_ck_prst", 64'(proc_reset_l), 64'd0);
    check_eq("bad_ck_done", 64'(done), 64'd0);
    check_eq("bad_ck_rdy", 64'(in_ready), 64'd0);
    do_reload();

    // Empty image.
    w0 = wcount;
    load_frame(0, 0, 1'b0, 1'b1, 1'b0, -1);
    expect_run("empty", 0);
    check_eq("empty_wcnt", 64'(wcount - w0), 64'd0);
    do_reload();

    // Oversize header: S+N = 260 > DEPTH.
    w0 = wcount;
    send({16'd250, 16'd10});
    check_eq("ovf_err", 64'(error), 64'd1);
    check_eq("ovf_rdy", 64'(in_ready), 64'd0);
    check_eq("ovf_prst", 64'(proc_reset_l), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("ovf_wcnt", 64'(wcount - w0), 64'd0);
    do_reload();

    // Exactly filling memory: S+N = DEPTH.
    w0 = wcount;
    load_frame(2, 254, 1'b0, 1'b0, 1'b0, -1);
    expect_run("edge", 254);
    check_eq("edge_wcnt", 64'(wcount - w0), 64'd2);
    do_reload();

    // 16 words gapless, then the same frame with random gaps.
    w0 = wcount;
    load_frame(16, 7, 1'b0, 1'b1, 1'b0, -1);
    expect_run("nogap", 7);
    gapless_cnt = wcount - w0;
    gapless_pc  = startPC;
    do_reload();
    w0 = wcount;
    load_frame(16, 7, 1'b0, 1'b1, 1'b1, -1);
    expect_run("gap", 7);
    gappy_cnt = wcount - w0;
    check_eq("gap_wcnt", 64'(gappy_cnt), 64'd16);
    check_eq("gap_vs_nogap_cnt", 64'(gappy_cnt), 64'(gapless_cnt));
    check_eq("gap_vs_nogap_pc", startPC, gapless_pc);
    do_reload();

    // Reset after 5 of 8 payload words: the fifth write is in flight.
    load_frame(8, 0, 1'b0, 1'b0, 1'b0, 5);
    #1;
    Reset_L = 1'b0;
    #1;
    check_eq("midrst_we", 64'(imem_we), 64'd0);
    check_eq("midrst_addr", imem_addr, 64'd0);
    check_eq("midrst_prst", 64'(proc_reset_l), 64'd0);
    check_eq("midrst_pc", startPC, BASE);
    check_eq("midrst_done", 64'(done), 64'd0);
    check_eq("midrst_err", 64'(error), 64'd0);
    @(posedge clk); #1;
    check_eq("midrst_pending", 64'(sb.size()), 64'd1);
    sb.delete();
    Reset_L = 1'b1;
    @(posedge clk); #1;
    w0 = wcount;
    load_frame(8, 0, 1'b0, 1'b0, 1'b0, -1);
    expect_run("after_rst", 0);
    check_eq("after_rst_wcnt", 64'(wcount - w0), 64'd8);

    repeat (3) @(posedge clk);
    #1;
    check_eq("final_sb", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
